// File: rtl/injection_sequencer.sv
// Four-channel injection sequencer: turns sync/event strobes into one-hot timed
// enable pulses in firing order, with overrun detection and run gating.
module injection_sequencer #(
  parameter int         PW_WIDTH     = 16,
  parameter int         PRESCALE     = 16,
  parameter logic [7:0] FIRING_ORDER = 8'b01_11_10_00
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic                i_sync,
  input  logic                i_event,
  input  logic [PW_WIDTH-1:0] i_pulse_width,
  input  logic [7:0]          i_dead_time,
  output logic [3:0]          o_enable,
  output logic [1:0]          o_slot,
  output logic                o_active,
  output logic                o_overrun
);

  // state     | meaning
  // IDLE      | not running, outputs cleared
  // WAIT_SYNC | running, waiting for cylinder-1 reference
  // ARMED     | synced, no pulse in progress
  // INJECT    | pulse in progress, duration counting down
  typedef enum logic [1:0] {IDLE, WAIT_SYNC, ARMED, INJECT} state_t;

  localparam int          D_W     = PW_WIDTH + 1;
  localparam logic [15:0] PS_LOAD = 16'(PRESCALE - 1);

  state_t         state, state_nxt;
  logic [D_W-1:0] dur, dur_nxt;
  logic [15:0]    presc, presc_nxt;
  logic [3:0]     enable_nxt;
  logic [1:0]     slot_nxt;
  logic           overrun_nxt;

  logic           accept;
  logic [1:0]     accept_slot;
  logic [1:0]     fire_idx;
  logic [D_W-1:0] d_new;

  always_comb begin
    d_new       = D_W'(i_pulse_width) + D_W'(i_dead_time);
    accept_slot = i_sync ? 2'd0 : o_slot + 2'd1;
    fire_idx    = FIRING_ORDER[{accept_slot, 1'b0} +: 2];
    accept      = i_run && ((state == WAIT_SYNC && i_sync) ||
                            ((state == ARMED || state == INJECT) && (i_sync || i_event)));
  end

  always_comb begin
    state_nxt   = state;
    dur_nxt     = dur;
    presc_nxt   = presc;
    enable_nxt  = o_enable;
    slot_nxt    = o_slot;
    overrun_nxt = o_overrun;

    if (!i_run) begin
      state_nxt   = IDLE;
      dur_nxt     = '0;
      presc_nxt   = '0;
      enable_nxt  = '0;
      slot_nxt    = 2'd0;
      overrun_nxt = 1'b0;
    end else if (accept) begin
      // an accept during INJECT truncates the old pulse and hands over directly
      slot_nxt = accept_slot;
      if (state == INJECT) overrun_nxt = 1'b1;
      if (d_new == '0) begin
        state_nxt  = ARMED;
        dur_nxt    = '0;
        presc_nxt  = '0;
        enable_nxt = '0;
      end else begin
        state_nxt  = INJECT;
        dur_nxt    = d_new;
        presc_nxt  = PS_LOAD;
        enable_nxt = 4'b0001 << fire_idx;
      end
    end else begin
      case (state)
        IDLE: state_nxt = WAIT_SYNC;
        INJECT: begin
          if (presc == '0) begin
            if (dur == D_W'(1)) begin
              state_nxt  = ARMED;
              dur_nxt    = '0;
              enable_nxt = '0;
            end else begin
              dur_nxt   = dur - D_W'(1);
              presc_nxt = PS_LOAD;
            end
          end else begin
            presc_nxt = presc - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      dur       <= '0;
      presc     <= '0;
      o_enable  <= '0;
      o_slot    <= 2'd0;
      o_active  <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      dur       <= dur_nxt;
      presc     <= presc_nxt;
      o_enable  <= enable_nxt;
      o_slot    <= slot_nxt;
      o_active  <= (state_nxt == INJECT);
      o_overrun <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_injection_sequencer.sv
// Bench for injection_sequencer: vector table, hand-written corner sequences and
// randomized strobes against a cycle-count reference model.
module tb_injection_sequencer;

  localparam int PRESCALE = 16;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_run = 1'b0;
  logic        i_sync = 1'b0;
  logic        i_event = 1'b0;
  logic [15:0] i_pulse_width = '0;
  logic [7:0]  i_dead_time = '0;
  logic [3:0]  o_enable;
  logic [1:0]  o_slot;
  logic        o_active;
  logic        o_overrun;

  injection_sequencer #(.PW_WIDTH(16), .PRESCALE(PRESCALE), .FIRING_ORDER(8'b01_11_10_00)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_sync(i_sync), .i_event(i_event),
    .i_pulse_width(i_pulse_width), .i_dead_time(i_dead_time),
    .o_enable(o_enable), .o_slot(o_slot), .o_active(o_active), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // reference model: phase 0 stopped, 1 awaiting sync, 2 synced; pulse as remaining high cycles
  int     order[4] = '{0, 2, 3, 1};
  int     m_phase = 0;
  int     m_slot = 0;
  longint m_rem = 0;
  bit     m_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (i_reset) begin
      m_phase = 0; m_slot = 0; m_rem = 0; m_ovr = 0;
    end else if (!i_run) begin
      m_phase = 0; m_slot = 0; m_rem = 0; m_ovr = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (i_sync || (m_phase == 2 && i_event)) begin
      if (m_rem > 0) m_ovr = 1;
      m_slot  = i_sync ? 0 : (m_slot + 1) % 4;
      m_rem   = (longint'(i_pulse_width) + longint'(i_dead_time)) * PRESCALE;
      m_phase = 2;
    end else if (m_rem > 0) begin
      m_rem--;
    end
  endtask

  task automatic check_model();
    logic [3:0] exp_en;
    exp_en = (m_rem > 0) ? (4'b0001 << order[m_slot]) : 4'b0000;
    chk("model", {24'd0, o_enable, o_slot, o_active, o_overrun},
        {24'd0, exp_en, 2'(m_slot), (m_rem > 0), m_ovr});
    chk("onehot0", {31'd0, $onehot0(o_enable)}, 32'd1);
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    check_model();
  endtask

  // counts cycles o_enable stays high; inputs wiggle to show they are ignored mid-pulse
  task automatic measure(output int cnt);
    cnt = 0;
    while (o_enable != 4'b0 && cnt < 2000) begin
      cnt++;
      i_pulse_width = 16'($urandom_range(0, 40));
      i_dead_time   = 8'($urandom);
      tick();
    end
  endtask

  task automatic strobe(input logic s, input logic e, input logic [15:0] pw, input logic [7:0] dt);
    i_sync = s; i_event = e; i_pulse_width = pw; i_dead_time = dt;
    tick();
    i_sync = 1'b0; i_event = 1'b0;
  endtask

  typedef struct {
    logic        sync;
    logic        evt;
    logic [15:0] pw;
    logic [7:0]  dt;
    logic [3:0]  en;
    logic [1:0]  slot;
    int          len;
  } vec_t;

  vec_t vecs[11];
  int   len;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 16'd10, 8'd2, 4'b0001, 2'd0, 192};
    vecs[1]  = '{1'b0, 1'b1, 16'd10, 8'd2, 4'b0100, 2'd1, 192};
    vecs[2]  = '{1'b0, 1'b1, 16'd10, 8'd2, 4'b1000, 2'd2, 192};
    vecs[3]  = '{1'b0, 1'b1, 16'd10, 8'd2, 4'b0010, 2'd3, 192};
    vecs[4]  = '{1'b0, 1'b1, 16'd0,  8'd0, 4'b0000, 2'd0, 0};
    vecs[5]  = '{1'b0, 1'b1, 16'd0,  8'd3, 4'b0100, 2'd1, 48};
    vecs[6]  = '{1'b1, 1'b1, 16'd4,  8'd0, 4'b0001, 2'd0, 64};
    vecs[7]  = '{1'b0, 1'b1, 16'd0,  8'd1, 4'b0100, 2'd1, 16};
    vecs[8]  = '{1'b0, 1'b1, 16'd2,  8'd0, 4'b1000, 2'd2, 32};
    vecs[9]  = '{1'b1, 1'b0, 16'd1,  8'd0, 4'b0001, 2'd0, 16};
    vecs[10] = '{1'b0, 1'b1, 16'd0,  8'd0, 4'b0000, 2'd1, 0};

    // reset state
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    chk("reset_outputs", {28'd0, o_enable, o_slot, o_active, o_overrun}, 32'd0);
    tick();
    i_reset = 1'b0;
    i_run = 1'b1;
    i_sync = 1'b1;                  // sync on the run rise must be ignored
    tick();
    i_sync = 1'b0;
    chk("sync_on_run_rise", {28'd0, o_enable}, 32'd0);
    i_event = 1'b1;                 // events ignored before sync
    tick();
    i_event = 1'b0;
    chk("event_before_sync", {28'd0, o_enable}, 32'd0);

    foreach (vecs[i]) begin
      strobe(vecs[i].sync, vecs[i].evt, vecs[i].pw, vecs[i].dt);
      chk($sformatf("vec%0d_enable", i), {28'd0, vecs[i].en}, {28'd0, o_enable});
      chk($sformatf("vec%0d_slot", i), {30'd0, o_slot}, {30'd0, vecs[i].slot});
      measure(len);
      chk($sformatf("vec%0d_len", i), len, vecs[i].len);
      chk($sformatf("vec%0d_overrun", i), {31'd0, o_overrun}, 32'd0);
      repeat (20) tick();
    end

    // overrun: new pulse replaces old in one edge
    strobe(1'b1, 1'b0, 16'd20, 8'd0);
    chk("ovr_first_en", {28'd0, o_enable}, 32'b0001);
    repeat (99) tick();
    chk("ovr_still_high", {28'd0, o_enable}, 32'b0001);
    strobe(1'b0, 1'b1, 16'd20, 8'd0);
    chk("ovr_switch_en", {28'd0, o_enable}, 32'b0100);
    chk("ovr_flag", {31'd0, o_overrun}, 32'd1);
    measure(len);
    chk("ovr_new_len", len, 320);
    chk("ovr_sticky", {31'd0, o_overrun}, 32'd1);

    // run drop mid-pulse
    strobe(1'b1, 1'b0, 16'd10, 8'd2);
    repeat (20) tick();
    i_run = 1'b0;
    tick();
    chk("rundrop_outputs", {28'd0, o_enable, o_slot, o_active, o_overrun}, 32'd0);
    i_run = 1'b1;
    tick();
    strobe(1'b0, 1'b1, 16'd10, 8'd2);
    chk("rundrop_event_ignored", {28'd0, o_enable}, 32'd0);
    repeat (3) tick();

    // back-to-back: first cycle after end is clean, last high cycle is overrun
    strobe(1'b1, 1'b0, 16'd1, 8'd0);
    measure(len);
    chk("b2b_len", len, 16);
    strobe(1'b0, 1'b1, 16'd1, 8'd0);
    chk("b2b_after_end_ovr", {31'd0, o_overrun}, 32'd0);
    chk("b2b_after_end_en", {28'd0, o_enable}, 32'b0100);
    repeat (15) tick();
    chk("b2b_last_high", {28'd0, o_enable}, 32'b0100);
    strobe(1'b0, 1'b1, 16'd1, 8'd0);
    chk("b2b_last_cycle_ovr", {31'd0, o_overrun}, 32'd1);
    chk("b2b_last_cycle_en", {28'd0, o_enable}, 32'b1000);
    i_run = 1'b0;
    tick();
    i_run = 1'b1;
    tick();

    // reset mid-pulse
    strobe(1'b1, 1'b0, 16'd10, 8'd2);
    repeat (49) tick();
    i_reset = 1'b1;
    #1;
    chk("midreset_outputs", {28'd0, o_enable, o_slot, o_active, o_overrun}, 32'd0);
    tick();
    i_reset = 1'b0;
    tick();
    strobe(1'b0, 1'b1, 16'd10, 8'd2);
    chk("midreset_event_ignored", {28'd0, o_enable}, 32'd0);
    strobe(1'b1, 1'b0, 16'd1, 8'd0);
    chk("midreset_resync", {28'd0, o_enable}, 32'b0001);
    measure(len);

    // full width: D must not wrap in the sum
    strobe(1'b1, 1'b0, 16'hFFFF, 8'hFF);
    repeat (20000) tick();
    chk("fullwidth_still_high", {28'd0, o_enable}, 32'b0001);
    i_run = 1'b0;
    tick();
    i_run = 1'b1;
    tick();

    // randomized strobes against the model
    for (int c = 0; c < 6000; c++) begin
      i_run         = ($urandom_range(0, 1999) != 0);
      i_sync        = ($urandom_range(0, 199) == 0);
      i_event       = ($urandom_range(0, 59) == 0);
      i_pulse_width = 16'($urandom_range(0, 15));
      i_dead_time   = 8'($urandom_range(0, 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
